// File: rtl/retire_trace_monitor_if.sv
// Retire-stream and trace-output bundle for retire_trace_monitor.
// Ports: ret_* carry one retiring instruction per cycle (producer -> monitor);
//        out_valid/out_ready/out_rec form the trace-record stream (monitor -> consumer).
interface retire_trace_monitor_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 32
);
  logic                     ret_valid;
  logic [DW-1:0]            ret_pc;
  logic                     ret_regwrite;
  logic [RW-1:0]            ret_wreg;
  logic [DW-1:0]            ret_wdata;
  logic                     ret_memread;
  logic                     ret_memwrite;
  logic [DW-1:0]            ret_addr;
  logic [DW-1:0]            ret_mdata;
  logic                     ret_halt;
  logic                     out_valid;
  logic                     out_ready;
  logic [CW+3+RW+3*DW-1:0]  out_rec;

  // Producer of retires and consumer of trace records (CPU side / bench).
  modport master (
    output ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
           ret_memread, ret_memwrite, ret_addr, ret_mdata, ret_halt,
    output out_ready,
    input  out_valid, out_rec
  );

  // The monitor itself.
  modport slave (
    input  ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
           ret_memread, ret_memwrite, ret_addr, ret_mdata, ret_halt,
    input  out_ready,
    output out_valid, out_rec
  );
endinterface

// File: rtl/retire_trace_monitor.sv
// Retire-stream monitor: classifies each retired instruction, packs it into a
// trace record {inum, halt, kind, wreg, pc, addr, val} and buffers it in a FIFO.
// Ports: clk/rst_n (sync, active-low); bus (slave) = retire inputs + record stream;
// fifo_level, cycle/inst/drop counters, overflow (sticky), done, timeout.
module retire_trace_monitor #(
  parameter int DW         = 16,
  parameter int RW         = 4,
  parameter int DEPTH      = 8,
  parameter int CW         = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  retire_trace_monitor_if.slave    bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CW-1:0]            cycle_count,
  output logic [CW-1:0]            inst_count,
  output logic [CW-1:0]            drop_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     timeout
);
  localparam int AW   = $clog2(DEPTH);
  localparam int RECW = CW + 3 + RW + 3*DW;

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_DONE, S_TIMEOUT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [CW-1:0]     cyc_q, cyc_d, inst_q, inst_d, drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [RECW-1:0]   mem_q [DEPTH];

  logic              accept, pop, full, push, drop;
  logic [1:0]        kind;
  logic [RW-1:0]     rec_wreg;
  logic [DW-1:0]     rec_addr, rec_val;
  logic [RECW-1:0]   rec;

  assign accept = (state_q == S_RUN) && bus.ret_valid;
  assign pop    = (level_q != '0) && bus.out_ready;
  assign full   = (level_q == (AW+1)'(DEPTH));
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  // Record classification; halt overrides everything and reports kind NONE.
  always_comb begin
    kind     = 2'b00;
    rec_wreg = '0;
    rec_addr = '0;
    rec_val  = '0;
    if (bus.ret_halt) begin
      kind = 2'b00;
    end else if (bus.ret_memwrite) begin
      kind     = 2'b11;
      rec_addr = bus.ret_addr;
      rec_val  = bus.ret_mdata;
    end else if (bus.ret_regwrite && bus.ret_memread) begin
      kind     = 2'b10;
      rec_wreg = bus.ret_wreg;
      rec_addr = bus.ret_addr;
      rec_val  = bus.ret_wdata;
    end else if (bus.ret_regwrite) begin
      kind     = 2'b01;
      rec_wreg = bus.ret_wreg;
      rec_val  = bus.ret_wdata;
    end
  end

  assign rec = {inst_q, bus.ret_halt, kind, rec_wreg, bus.ret_pc, rec_addr, rec_val};

  // State machine and cycle counter (counts only while running).
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (accept && bus.ret_halt)             state_d = S_HALTED;
        else if (cyc_q == CW'(MAX_CYCLES - 1))  state_d = S_TIMEOUT;
      end
      S_HALTED: if (level_q == '0) state_d = S_DONE;
      default: ;
    endcase
  end

  // Counters and FIFO bookkeeping.
  always_comb begin
    inst_d   = accept ? inst_q + CW'(1) : inst_q;
    drop_d   = drop   ? drop_q + CW'(1) : drop_q;
    ovf_d    = ovf_q | drop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cyc_q    <= '0;
      inst_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cyc_q    <= cyc_d;
      inst_q   <= inst_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: out_valid is derived from the level alone.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= rec;
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_rec   = mem_q[rd_ptr_q];
  assign fifo_level    = level_q;
  assign cycle_count   = cyc_q;
  assign inst_count    = inst_q;
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;
  assign done          = (state_q == S_DONE);
  assign timeout       = (state_q == S_TIMEOUT);
endmodule

// File: tb/tb_retire_trace_monitor.sv
module tb_retire_trace_monitor;
  localparam int DW = 16, RW = 4, DEPTH = 8, CW = 32, MAXC = 20;
  localparam int RECW = CW + 3 + RW + 3*DW;
  typedef logic [RECW-1:0] rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  retire_trace_monitor_if #(.DW(DW), .RW(RW), .CW(CW)) bus();

  logic [3:0]    fifo_level;
  logic [CW-1:0] cycle_count, inst_count, drop_count;
  logic          overflow, done, timeout;

  retire_trace_monitor #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .CW(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fifo_level(fifo_level), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .done(done), .timeout(timeout)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of expected records plus plain counters/flags.
  rec_t m_q[$];
  int   m_cyc, m_inst, m_drop;
  bit   m_ovf, m_halted, m_done, m_to;

  function automatic rec_t mk(logic [31:0] inum, logic h, logic [1:0] k, logic [3:0] wr,
                              logic [15:0] pc, logic [15:0] ad, logic [15:0] v);
    return {inum, h, k, wr, pc, ad, v};
  endfunction

  function automatic rec_t expected_rec(int inum);
    if (bus.ret_halt)
      return mk(inum, 1'b1, 2'b00, 4'd0, bus.ret_pc, 16'd0, 16'd0);
    if (bus.ret_memwrite)
      return mk(inum, 1'b0, 2'b11, 4'd0, bus.ret_pc, bus.ret_addr, bus.ret_mdata);
    if (bus.ret_regwrite && bus.ret_memread)
      return mk(inum, 1'b0, 2'b10, bus.ret_wreg, bus.ret_pc, bus.ret_addr, bus.ret_wdata);
    if (bus.ret_regwrite)
      return mk(inum, 1'b0, 2'b01, bus.ret_wreg, bus.ret_pc, 16'd0, bus.ret_wdata);
    return mk(inum, 1'b0, 2'b00, 4'd0, bus.ret_pc, 16'd0, 16'd0);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit running, popped;
    int pre_size;
    if (!rst_n) begin
      m_q.delete();
      m_cyc = 0; m_inst = 0; m_drop = 0;
      m_ovf = 0; m_halted = 0; m_done = 0; m_to = 0;
      return;
    end
    pre_size = m_q.size();
    running  = !m_halted && !m_to;
    popped   = (pre_size > 0) && bus.out_ready;
    if (popped) void'(m_q.pop_front());
    if (running && bus.ret_valid) begin
      if (pre_size < DEPTH || popped) m_q.push_back(expected_rec(m_inst));
      else begin m_drop++; m_ovf = 1; end
      m_inst++;
    end
    if (m_halted && !m_done && pre_size == 0) m_done = 1;
    if (running) begin
      if (bus.ret_valid && bus.ret_halt) m_halted = 1;
      else if (m_cyc == MAXC - 1)        m_to = 1;
      m_cyc++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ret_valid = 0; bus.ret_pc = '0; bus.ret_regwrite = 0; bus.ret_wreg = '0;
    bus.ret_wdata = '0; bus.ret_memread = 0; bus.ret_memwrite = 0; bus.ret_addr = '0;
    bus.ret_mdata = '0; bus.ret_halt = 0;
  endtask

  task automatic ret(logic [15:0] pc, logic rw, logic [3:0] wr, logic [15:0] wd, logic mr,
                     logic mw, logic [15:0] ad, logic [15:0] md, logic h);
    bus.ret_valid = 1; bus.ret_pc = pc; bus.ret_regwrite = rw; bus.ret_wreg = wr;
    bus.ret_wdata = wd; bus.ret_memread = mr; bus.ret_memwrite = mw; bus.ret_addr = ad;
    bus.ret_mdata = md; bus.ret_halt = h;
  endtask

  task automatic rand_ret(bit allow_halt);
    ret(16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
        ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom),
        allow_halt && ($urandom_range(0, 15) == 0));
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    bus.out_ready = 0;
    cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.out_valid, overflow, done, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/ovf/done/to=%b required 0000",
               {bus.out_valid, overflow, done, timeout});
    end
    n_cmp++;
    if (fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d required 0", fifo_level);
    end
    n_cmp++;
    if ({cycle_count, inst_count, drop_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got cyc=%0d inst=%0d drop=%0d required 0/0/0",
               cycle_count, inst_count, drop_count);
    end
  endtask

  task automatic test_reg();
    do_reset();
    ret(16'h0000, 1, 4'd3, 16'h1234, 0, 0, 16'h5555, 16'h6666, 0);
    cycle();
    idle();
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reg_valid: got %b required 1", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_rec !== mk(0, 0, 2'b01, 4'd3, 16'h0000, 16'h0000, 16'h1234)) begin
      n_fail++; $display("FAIL reg_rec: got %h required %h", bus.out_rec,
                         mk(0, 0, 2'b01, 4'd3, 16'h0000, 16'h0000, 16'h1234));
    end
    n_cmp++;
    if (inst_count !== 32'd1) begin
      n_fail++; $display("FAIL reg_inst: got %0d required 1", inst_count);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    ret(16'h0002, 1, 4'd2, 16'hBEEF, 1, 0, 16'h0040, 16'h7777, 0);
    cycle();
    ret(16'h0004, 1, 4'd5, 16'h1111, 0, 1, 16'h0042, 16'h00FF, 0);
    cycle();
    idle();
    n_cmp++;
    if (bus.out_rec !== mk(0, 0, 2'b10, 4'd2, 16'h0002, 16'h0040, 16'hBEEF)) begin
      n_fail++; $display("FAIL load_rec: got %h required %h", bus.out_rec,
                         mk(0, 0, 2'b10, 4'd2, 16'h0002, 16'h0040, 16'hBEEF));
    end
    bus.out_ready = 1;
    cycle();
    n_cmp++;
    if (bus.out_rec !== mk(1, 0, 2'b11, 4'd0, 16'h0004, 16'h0042, 16'h00FF)) begin
      n_fail++; $display("FAIL store_rec: got %h required %h", bus.out_rec,
                         mk(1, 0, 2'b11, 4'd0, 16'h0004, 16'h0042, 16'h00FF));
    end
    cycle();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL ls_drained: got valid=%b level=%0d required 0/0",
                         bus.out_valid, fifo_level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ret(16'(2*i), 1, 4'(i), 16'(i + 16'h100), 0, 0, 16'd0, 16'd0, 0);
      cycle();
    end
    idle();
    n_cmp++;
    if (fifo_level !== 4'd8 || drop_count !== 32'd2 || overflow !== 1'b1 || inst_count !== 32'd10) begin
      n_fail++;
      $display("FAIL ovf_state: got level=%0d drop=%0d ovf=%b inst=%0d required 8/2/1/10",
               fifo_level, drop_count, overflow, inst_count);
    end
    ret(16'h0080, 1, 4'd9, 16'hCAFE, 0, 0, 16'd0, 16'd0, 0);
    bus.out_ready = 1;
    cycle();
    idle();
    bus.out_ready = 0;
    n_cmp++;
    if (fifo_level !== 4'd8 || drop_count !== 32'd2 || inst_count !== 32'd11) begin
      n_fail++;
      $display("FAIL full_pushpop: got level=%0d drop=%0d inst=%0d required 8/2/11",
               fifo_level, drop_count, inst_count);
    end
    n_cmp++;
    if (bus.out_rec !== mk(1, 0, 2'b01, 4'd1, 16'h0002, 16'h0000, 16'h0101)) begin
      n_fail++; $display("FAIL full_head: got %h required %h", bus.out_rec,
                         mk(1, 0, 2'b01, 4'd1, 16'h0002, 16'h0000, 16'h0101));
    end
  endtask

  task automatic test_halt();
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ret(16'(2*i), 1, 4'(i + 1), 16'(16'h0A00 + i), 0, 0, 16'd0, 16'd0, 0);
      cycle();
    end
    ret(16'h0010, 1, 4'd7, 16'h9999, 0, 1, 16'h0020, 16'h3333, 1);
    bus.out_ready = 1;
    cycle();
    n_cmp++;
    if (fifo_level !== 4'd3 || cycle_count !== 32'd4) begin
      n_fail++; $display("FAIL halt_enter: got level=%0d cyc=%0d required 3/4",
                         fifo_level, cycle_count);
    end
    for (k = 0; k < 20 && !done; k++) begin
      rand_ret(0);
      if (m_q.size() != 0) begin
        n_cmp++;
        if (bus.out_rec !== m_q[0]) begin
          n_fail++; $display("FAIL halt_drain_rec: got %h required %h", bus.out_rec, m_q[0]);
        end
      end
      cycle();
      n_cmp++;
      if (done !== m_done) begin
        n_fail++; $display("FAIL halt_done_timing: got %b required %b", done, m_done);
      end
    end
    idle();
    n_cmp++;
    if (done !== 1'b1 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL halt_done: got done=%b level=%0d required 1/0", done, fifo_level);
    end
    n_cmp++;
    if (inst_count !== 32'd4 || cycle_count !== 32'd4) begin
      n_fail++; $display("FAIL halt_frozen: got inst=%0d cyc=%0d required 4/4",
                         inst_count, cycle_count);
    end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    bus.out_ready = 1;
    for (k = 1; k <= 40 && !timeout; k++) begin
      cycle();
      if (k == 19) begin
        n_cmp++;
        if (timeout !== 1'b0) begin
          n_fail++; $display("FAIL timeout_early: got %b required 0 at cycle 19", timeout);
        end
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || cycle_count !== 32'd20) begin
      n_fail++; $display("FAIL timeout_fire: got to=%b cyc=%0d required 1/20",
                         timeout, cycle_count);
    end
    ret(16'h0100, 1, 4'd1, 16'h4444, 0, 0, 16'd0, 16'd0, 0);
    cycle();
    cycle();
    idle();
    n_cmp++;
    if (inst_count !== 32'd0 || fifo_level !== 4'd0 || cycle_count !== 32'd20) begin
      n_fail++; $display("FAIL timeout_ignore: got inst=%0d level=%0d cyc=%0d required 0/0/20",
                         inst_count, fifo_level, cycle_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_ret(0);
      cycle();
    end
    rst_n = 0;
    cycle();
    rst_n = 1;
    idle();
    n_cmp++;
    if (fifo_level !== 4'd0 || bus.out_valid !== 1'b0 || inst_count !== 32'd0 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL midreset: got level=%0d valid=%b inst=%0d cyc=%0d required 0/0/0/0",
                         fifo_level, bus.out_valid, inst_count, cycle_count);
    end
    cycle();
    n_cmp++;
    if (cycle_count !== 32'd1 || timeout !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_run: got cyc=%0d to=%b done=%b required 1/0/0",
                         cycle_count, timeout, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < 32; c++) begin
        if ($urandom_range(0, 3) != 0) rand_ret(1); else idle();
        bus.out_ready = 1'($urandom);
        cycle();
        n_cmp++;
        if (bus.out_valid !== (m_q.size() != 0) || fifo_level !== 4'(m_q.size())) begin
          n_fail++; $display("FAIL rnd_level: got valid=%b level=%0d required level %0d",
                             bus.out_valid, fifo_level, m_q.size());
        end
        if (m_q.size() != 0) begin
          n_cmp++;
          if (bus.out_rec !== m_q[0]) begin
            n_fail++; $display("FAIL rnd_rec: got %h required %h", bus.out_rec, m_q[0]);
          end
        end
        n_cmp++;
        if ({cycle_count, inst_count, drop_count} !== {32'(m_cyc), 32'(m_inst), 32'(m_drop)}) begin
          n_fail++; $display("FAIL rnd_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
                             cycle_count, inst_count, drop_count, m_cyc, m_inst, m_drop);
        end
        n_cmp++;
        if ({overflow, done, timeout} !== {m_ovf, m_done, m_to}) begin
          n_fail++; $display("FAIL rnd_flags: got ovf/done/to=%b required %b",
                             {overflow, done, timeout}, {m_ovf, m_done, m_to});
        end
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    bus.out_ready = 0;
    test_reset();
    test_reg();
    test_load_store();
    test_overflow();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_trace_monitor.md
Name: retire_trace_monitor

Overview:
Synthesizable retire-stream monitor for the pipelined 16-bit CPU. It sits beside the writeback stage and classifies each retired instruction as a REG write, LOAD, STORE or NONE (branch/NOP), with halt flagged separately. Each retire is packed into a trace record and buffered in a FIFO drained over a valid/ready port. It also keeps cycle and instruction counters, detects halt completion and enforces a cycle-limit watchdog. It replaces bench-only trace printing with hardware usable in simulation and on FPGA.

Parameters:
DW, 16, data/address/PC width
RW, 4, register index width
DEPTH, 8, FIFO entries (power of 2, >=2)
CW, 32, counter and instruction-number width
MAX_CYCLES, 100000, watchdog limit in RUN cycles

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ret_valid  in  1  an instruction retires this cycle
ret_pc  in  DW  PC of retiring instruction
ret_regwrite  in  1  register write
ret_wreg  in  RW  destination register
ret_wdata  in  DW  register write data
ret_memread  in  1  load
ret_memwrite  in  1  store
ret_addr  in  DW  memory address
ret_mdata  in  DW  store data
ret_halt  in  1  retiring instruction is HLT
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_rec  out  CW+3+RW+3*DW  {inum, halt, kind[1:0], wreg, pc, addr, val}
fifo_level  out  log2(DEPTH)+1  occupancy
cycle_count  out  CW  RUN cycles elapsed
inst_count  out  CW  instructions retired
drop_count  out  CW  records lost to overflow
overflow  out  1  sticky: any drop
done  out  1  halt retired and FIFO drained
timeout  out  1  watchdog fired

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN; FIFO empty; all counters 0; overflow/done/timeout 0; out_valid 0. Reset mid-operation discards FIFO contents immediately.
- Decided: reset rst_n, synchronous, active-low; clock clk.
- States: RUN -> HALTED on an accepted ret_valid&&ret_halt; RUN -> TIMEOUT when cycle_count==MAX_CYCLES-1 and no halt that cycle; HALTED -> DONE when FIFO empty; DONE and TIMEOUT are terminal until reset.
- cycle_count increments every RUN cycle, including the halt cycle; frozen otherwise.
- Retires are accepted in RUN only; ret_valid in other states is ignored (no count, no record).
- Kind precedence: memwrite -> STORE(11): wreg=0, addr=ret_addr, val=ret_mdata. Else regwrite&&memread -> LOAD(10): wreg, addr, val=wdata. Else regwrite -> REG(01): wreg, addr=0, val=wdata. Else NONE(00): wreg/addr/val=0.
- Halt record: halt=1, kind NONE.
- inum = inst_count before increment (0-based). inst_count increments on every accepted retire, including dropped ones and the halt.
- Push latency: a record is visible at out_rec/out_valid the cycle after retire. out_rec reads combinationally from the registered head; FIFO order is strict.
- Pop when out_valid&&out_ready.
- Full boundary: a push while full succeeds if a pop occurs the same cycle. Otherwise the record is dropped, drop_count++ and overflow=1. A dropped halt record still moves the state to HALTED.
- Simultaneous push and pop leave the level unchanged. Pointers wrap modulo DEPTH.
- done=1 in DONE; timeout=1 in TIMEOUT; both are level outputs.
- In TIMEOUT the FIFO remains drainable.

Test Plan:
- Reset, then REG retire pc=0x0000 wreg=3 wdata=0x1234 -> next cycle out_valid=1, kind=01, inum=0, val=0x1234; inst_count=1.
- LOAD wreg=2 addr=0x0040 wdata=0xBEEF, then STORE addr=0x0042 mdata=0x00FF with regwrite=1 -> records kind 10 then 11 in order, STORE wreg=0.
- out_ready=0, 10 retires with DEPTH=8 -> level=8, drop_count=2, overflow=1, inst_count=10. Then pop+push in the same cycle -> accepted, level stays 8.
- Halt at pc=0x0010 with 3 records queued, out_ready=1 -> state HALTED; retires after that are ignored; done=1 the cycle after the FIFO empties; cycle_count is frozen.
- MAX_CYCLES=20, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20; later retires are ignored.
- Assert rst_n=0 mid-stream with 5 records queued -> next cycle level=0, counters 0, state RUN.
